// File: rtl/mux_arbiter_pkg.sv
// Shared defaults, state encoding and the round-robin search helper for mux_arbiter.
package mux_arbiter_pkg;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned W_DEF     = 8;
    localparam int unsigned BURST_DEF = 1;

    // Upper bound on requesters handled by the shared search function.
    localparam int unsigned MAX_N = 32;
    localparam int unsigned IDX_W = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // First valid requester searching upward from last+1 with wrap-around over n slots.
    function automatic pick_t rr_next(input int unsigned n,
                                      input int unsigned last,
                                      input logic [MAX_N-1:0] valid);
        pick_t       res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_N; k++) begin
            cand = last + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((k <= n) && !res.found && valid[IDX_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin priority picker over N valid lines.
module rr_pick
    import mux_arbiter_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          found
);

    pick_t pick;
    logic  unused_idx;

    always_comb begin
        pick = rr_next(N, 32'(last), MAX_N'(valid));
    end

    assign winner     = pick.idx[IW-1:0];
    assign found      = pick.found;
    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin N:1 arbiter with optional burst lock feeding a single registered output stage.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter  int unsigned N     = N_DEF,
    parameter  int unsigned W     = W_DEF,
    parameter  int unsigned BURST = BURST_DEF,
    localparam int unsigned IW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_id,
    input  logic           out_ready
);

    localparam int unsigned BCW = $clog2(BURST + 1);

    state_t         state_q;
    state_t         state_d;
    logic [IW-1:0]  last_q;
    logic [IW-1:0]  lock_id_q;
    logic [BCW-1:0] bcnt_q;

    logic [IW-1:0]  pick_id;
    logic           pick_found;
    logic [IW-1:0]  win_id;
    logic           win_found;
    logic           lock_act;
    logic           lock_hold;
    logic           accept;
    logic           xfer;
    logic [W-1:0]   win_data;
    logic [W-1:0]   lanes [N];

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lanes[g] = req_data[g*W +: W];
    end

    rr_pick #(.N(N)) u_pick (
        .valid  (req_valid),
        .last   (last_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    // Winner selection: an active lock whose owner is still valid overrides rotation.
    always_comb begin
        lock_act  = (bcnt_q != '0) && (bcnt_q < BCW'(BURST));
        lock_hold = lock_act && req_valid[lock_id_q];
        win_id    = lock_hold ? lock_id_q : pick_id;
        win_found = lock_hold || pick_found;
        accept    = !out_valid || out_ready;
        xfer      = win_found && accept;
        win_data  = lanes[win_id];
        // Reset gates grants immediately, independent of the clock.
        req_ready = (xfer && rst_n) ? (N'(1) << win_id) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!xfer && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
    end

    // Output stage and rotation pointer load only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= '0;
            last_q   <= IW'(N - 1);
        end else if (xfer) begin
            out_data <= win_data;
            out_id   <= win_id;
            last_q   <= win_id;
        end
    end

    // Burst bookkeeping; a lock owner dropping valid releases the lock at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q    <= '0;
            lock_id_q <= '0;
        end else if (xfer) begin
            if (lock_hold) begin
                bcnt_q <= bcnt_q + BCW'(1);
            end else begin
                bcnt_q    <= BCW'(1);
                lock_id_q <= win_id;
            end
        end else if (lock_act && !req_valid[lock_id_q]) begin
            bcnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench: BURST=1 and BURST=3 instances driven side by side against a reference model.
module tb_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   rv   [2];
    logic [N*W-1:0] rd   [2];
    logic           ordy [2];
    logic [N-1:0]   rr   [2];
    logic           ov   [2];
    logic [W-1:0]   od   [2];
    logic [1:0]     oid  [2];

    mux_arbiter #(.N(N), .W(W), .BURST(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_id(oid[0]), .out_ready(ordy[0])
    );

    mux_arbiter #(.N(N), .W(W), .BURST(3)) dut_b3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_id(oid[1]), .out_ready(ordy[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: who was served last, who holds the lock and how many beats it has had.
    int         m_last [2];
    int         m_lock [2];
    int         m_cnt  [2];
    logic       m_ov   [2];
    logic [W-1:0] m_od [2];
    int         m_oid  [2];

    function automatic int burst_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_locked(input int d);
        return (m_cnt[d] > 0) && (m_cnt[d] < burst_of(d));
    endfunction

    function automatic int model_winner(input int d);
        if (model_locked(d) && rv[d][m_lock[d]]) return m_lock[d];
        for (int k = 1; k <= N; k++) begin
            int idx = (m_last[d] + k) % N;
            if (rv[d][idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = N - 1;
            m_lock[d] = 0;
            m_cnt[d]  = 0;
            m_ov[d]   = 1'b0;
            m_od[d]   = '0;
            m_oid[d]  = 0;
        end
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic r);
        for (int d = 0; d < 2; d++) begin
            rv[d]   = v;
            ordy[d] = r;
            for (int i = 0; i < N; i++) rd[d][i*W +: W] = W'($urandom);
        end
    endtask

    // One clock: check grants before the edge, advance the model, check the output stage after.
    // g0/g1: required grant index per instance, -1 for no grant, -2 for model-only.
    task automatic cycle(input string tag, input int g0, input int g1);
        int   g   [2];
        int   win [2];
        bit   xf  [2];
        bit   lk  [2];
        int   exp;
        g[0] = g0;
        g[1] = g1;
        #1;
        for (int d = 0; d < 2; d++) begin
            win[d] = model_winner(d);
            lk[d]  = model_locked(d);
            xf[d]  = (win[d] >= 0) && (!m_ov[d] || ordy[d]);
            exp    = xf[d] ? (1 << win[d]) : 0;
            chk($sformatf("%s_ready_d%0d", tag, d), 32'(rr[d]), exp);
            if (g[d] >= 0)
                chk($sformatf("%s_grant_d%0d", tag, d), 32'(rr[d]), 32'(1) << g[d]);
            else if (g[d] == -1)
                chk($sformatf("%s_nogrant_d%0d", tag, d), 32'(rr[d]), 32'd0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (xf[d]) begin
                m_od[d]  = rd[d][win[d]*W +: W];
                m_oid[d] = win[d];
                m_ov[d]  = 1'b1;
                if (lk[d] && win[d] == m_lock[d]) begin
                    m_cnt[d]++;
                end else begin
                    m_cnt[d]  = 1;
                    m_lock[d] = win[d];
                end
                m_last[d] = win[d];
            end else begin
                if (ordy[d]) m_ov[d] = 1'b0;
                if (lk[d] && !rv[d][m_lock[d]]) m_cnt[d] = 0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_valid_d%0d", tag, d), 32'(ov[d]), 32'(m_ov[d]));
            chk($sformatf("%s_data_d%0d", tag, d), 32'(od[d]), 32'(m_od[d]));
            chk($sformatf("%s_id_d%0d", tag, d), 32'(oid[d]), 32'(m_oid[d]));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in('0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] saved;
        int           exp_b [10];
        exp_b = '{1, 1, 1, 2, 2, 2, 1, 1, 1, 2};

        rst_n = 1'b0;
        set_in('0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid_d%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("reset_data_d%0d", d), 32'(od[d]), 32'd0);
            chk($sformatf("reset_id_d%0d", d), 32'(oid[d]), 32'd0);
            chk($sformatf("reset_ready_d%0d", d), 32'(rr[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Plain rotation from reset
        for (int k = 0; k < 5; k++) begin
            set_in(4'hF, 1'b1);
            cycle("rr", k % 4, -2);
            chk("rr_out_id", 32'(oid[0]), 32'(k % 4));
        end

        // Back-pressure holds the output stage and blocks all grants
        do_reset();
        set_in(4'hF, 1'b1);
        cycle("bp_load", 0, 0);
        saved = od[0];
        for (int k = 0; k < 3; k++) begin
            set_in(4'hF, 1'b0);
            cycle("bp_stall", -1, -1);
            chk("bp_hold_data", 32'(od[0]), 32'(saved));
            chk("bp_hold_id", 32'(oid[0]), 32'd0);
        end
        set_in(4'hF, 1'b1);
        cycle("bp_resume", 1, 0);
        set_in(4'hF, 1'b1);
        cycle("bp_resume", 2, 0);

        // Burst lock on the BURST=3 instance, then lock owner drops valid
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_in(4'b0110, 1'b1);
            cycle("burst", -2, exp_b[k]);
        end
        set_in(4'b0010, 1'b1);
        cycle("burst_drop", -2, 1);

        // Sparse requesters and wrap-around
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(4'b1000, 1'b1);
            cycle("sparse", 3, 3);
        end
        set_in(4'b1001, 1'b1);
        cycle("sparse_wrap", 0, 0);
        saved = od[0];

        // Drain with no requesters
        set_in('0, 1'b1);
        cycle("drain", -1, -1);
        chk("drain_valid", 32'(ov[0]), 32'd0);
        chk("drain_hold", 32'(od[0]), 32'(saved));

        // Asynchronous reset between clock edges
        do_reset();
        set_in(4'hF, 1'b1);
        cycle("ar_pre", 0, 0);
        set_in(4'hF, 1'b1);
        cycle("ar_pre", 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ar_valid_d%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("ar_ready_d%0d", d), 32'(rr[d]), 32'd0);
            chk($sformatf("ar_data_d%0d", d), 32'(od[d]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(4'hF, 1'b1);
        cycle("ar_restart", 0, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            set_in(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            cycle("rand", -2, -2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
